// File: rtl/divu_pkg.sv
// Shared types and default sizing for the unsigned divider sequencer.
package divu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/divu_iter_cnt.sv
// Iteration counter: synchronous clear, saturating increment, terminal count at WIDTH-1.
module divu_iter_cnt
  import divu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !tc)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/divu_ctrl.sv
// Sequencer for a shift/subtract unsigned divider datapath.
// Optional divide-by-zero short cut: define DIVU_CTRL_DZ_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// LOAD  | dividend written into the remainder register
// ITER  | one shift/subtract step per cycle, WIDTH cycles
// FIXUP | right-shift correction of the remainder upper half
// DONE  | result valid; start launches the next operation
module divu_ctrl
  import divu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             divisor_zero,
  output logic             w_ctrl_reg2,
  output logic             srl_ctrl,
  output logic             shift_en,
  output logic             busy,
  output logic             rdy,
  output logic             dz,
  output logic [CNT_W-1:0] iter
);

  state_t state, state_nxt;
  logic   accept;
  logic   tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    w_ctrl_reg2 = 1'b0;
    shift_en    = 1'b0;
    srl_ctrl    = 1'b0;
    busy        = 1'b0;
    rdy         = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        rdy = (state == S_DONE);
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_LOAD;
`ifdef DIVU_CTRL_DZ_CHECK_EN
          if (divisor_zero)
            state_nxt = S_DONE;
`endif
        end
      end
      S_LOAD: begin
        w_ctrl_reg2 = 1'b1;
        busy        = 1'b1;
        state_nxt   = S_ITER;
      end
      S_ITER: begin
        shift_en = 1'b1;
        busy     = 1'b1;
        if (tc)
          state_nxt = S_FIXUP;
      end
      S_FIXUP: begin
        srl_ctrl  = 1'b1;
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Clearing on entry to LOAD makes iter read 0 during LOAD and the first ITER cycle.
  divu_iter_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_nxt == S_LOAD),
    .inc (state == S_ITER),
    .cnt (iter),
    .tc  (tc)
  );

`ifdef DIVU_CTRL_DZ_CHECK_EN
  logic dz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dz_q <= 1'b0;
    else if (accept)
      dz_q <= divisor_zero;
  end

  assign dz = dz_q;
`else
  logic unused_dz_inputs;
  assign unused_dz_inputs = divisor_zero ^ accept;
  assign dz = 1'b0;
`endif

endmodule
